// File: rtl/portin_pkg.sv
// Shared types and helpers for the router input port.
package portin_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        PAYLOAD,
        DROP
    } state_t;

    // {frame_n, valid_n} cycle codes
    localparam logic [1:0] FR_PAY  = 2'b00;
    localparam logic [1:0] FR_ADDR = 2'b01;
    localparam logic [1:0] FR_LAST = 2'b10;
    localparam logic [1:0] FR_IDLE = 2'b11;

    // Smallest r such that 2**r >= v.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/portin_fifo.sv
// First-word-fall-through packet FIFO. The head word is presented combinationally;
// while empty, the output holds the last head word that was shown.
module portin_fifo
    import portin_pkg::*;
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic [WIDTH-1:0] last_head;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? last_head : mem[rd_ptr];

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_head <= '0;
        end else begin
            last_head <= dout;
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/portin_q.sv
// Router input port: deserialises bit-serial frames, checks length and queues
// complete packets for the downstream arbiter.
//
//  state   | meaning
//  IDLE    | waiting for the first address bit
//  ADDR    | collecting address bits (extra bits beyond ADDR_W ignored)
//  PAYLOAD | collecting payload bits until the last-bit marker
//  DROP    | discarding the rest of a malformed frame
module portin_q
    import portin_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_n,
    input  logic              valid_n,
    input  logic              di,
    input  logic              granted,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] payload,
    output logic              vld,
    output logic              busy,
    output logic              full,
    output logic              err_len,
    output logic              err_ovf
);

    localparam int CA_W = clog2(ADDR_W + 1);
    localparam int CP_W = clog2(DATA_W + 2);
    localparam logic [CA_W-1:0]   CA_MAX  = CA_W'(ADDR_W);
    localparam logic [CP_W-1:0]   CP_DW   = CP_W'(DATA_W);
    localparam logic [CP_W-1:0]   CP_LAST = CP_W'(DATA_W - 1);
    localparam logic [CP_W-1:0]   CP_SAT  = CP_W'(DATA_W + 1);
    localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
    localparam logic [DATA_W-1:0] P_ONE   = DATA_W'(1);

    state_t             state, state_next;
    logic [CA_W-1:0]    cnta, cnta_next;
    logic [CP_W-1:0]    cntp, cntp_next;
    logic [ADDR_W-1:0]  addr_sr, addr_sr_next;
    logic [DATA_W-1:0]  pay_sr, pay_sr_next;
    logic               err_len_next, err_ovf_next;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [1:0]         code;
    logic [ADDR_W+DATA_W-1:0] push_data;
    logic [ADDR_W+DATA_W-1:0] head;

    assign code      = {frame_n, valid_n};
    assign pop       = granted && !fifo_empty;
    assign vld       = !fifo_empty;
    assign busy      = (state != IDLE);
    // The last payload bit arrives with the end marker and goes straight into the queue.
    assign push_data = {addr_sr, di, pay_sr[DATA_W-2:0]};
    assign addr      = head[ADDR_W+DATA_W-1:DATA_W];
    assign payload   = head[DATA_W-1:0];

    portin_fifo #(
        .WIDTH(ADDR_W + DATA_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock(clock),
        .reset(reset),
        .push (push),
        .pop  (pop),
        .din  (push_data),
        .dout (head),
        .full (full),
        .empty(fifo_empty)
    );

    // State, counters, shift registers and registered error pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnta    <= '0;
            cntp    <= '0;
            addr_sr <= '0;
            pay_sr  <= '0;
            err_len <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            state   <= state_next;
            cnta    <= cnta_next;
            cntp    <= cntp_next;
            addr_sr <= addr_sr_next;
            pay_sr  <= pay_sr_next;
            err_len <= err_len_next;
            err_ovf <= err_ovf_next;
        end
    end

    // Frame decode: next state, bit capture, push and error decisions.
    always_comb begin
        state_next   = state;
        cnta_next    = cnta;
        cntp_next    = cntp;
        addr_sr_next = addr_sr;
        pay_sr_next  = pay_sr;
        err_len_next = 1'b0;
        err_ovf_next = 1'b0;
        push         = 1'b0;
        unique case (state)
            IDLE: begin
                if (code == FR_ADDR) begin
                    addr_sr_next = (addr_sr & ~A_ONE) | ADDR_W'(di);
                    cnta_next    = CA_W'(1);
                    state_next   = ADDR;
                end else if (code == FR_PAY || code == FR_LAST) begin
                    err_len_next = 1'b1;
                end
            end
            ADDR: begin
                unique case (code)
                    FR_ADDR: begin
                        if (cnta < CA_MAX) begin
                            addr_sr_next = (addr_sr & ~(A_ONE << cnta)) | (ADDR_W'(di) << cnta);
                            cnta_next    = cnta + 1'b1;
                        end
                    end
                    FR_PAY: begin
                        if (cnta < CA_MAX) begin
                            err_len_next = 1'b1;
                            state_next   = DROP;
                        end else begin
                            pay_sr_next = (pay_sr & ~P_ONE) | DATA_W'(di);
                            cntp_next   = CP_W'(1);
                            state_next  = PAYLOAD;
                        end
                    end
                    default: begin
                        err_len_next = 1'b1;
                        state_next   = IDLE;
                    end
                endcase
            end
            PAYLOAD: begin
                unique case (code)
                    FR_PAY: begin
                        if (cntp < CP_DW)
                            pay_sr_next = (pay_sr & ~(P_ONE << cntp)) | (DATA_W'(di) << cntp);
                        if (cntp != CP_SAT) cntp_next = cntp + 1'b1;
                    end
                    FR_LAST: begin
                        state_next = IDLE;
                        if (cntp != CP_LAST) err_len_next = 1'b1;
                        else if (full && !pop) err_ovf_next = 1'b1;
                        else push = 1'b1;
                    end
                    FR_ADDR: begin
                        err_len_next = 1'b1;
                        state_next   = DROP;
                    end
                    default: begin
                        err_len_next = 1'b1;
                        state_next   = IDLE;
                    end
                endcase
            end
            DROP: begin
                if (code == FR_LAST || code == FR_IDLE) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_portin_q.sv
// Self-checking bench for portin_q: directed scenarios plus randomized frames
// checked against a packet-level queue model.
module tb_portin_q;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int DP = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          frame_n = 1'b1;
    logic          valid_n = 1'b1;
    logic          di = 1'b0;
    logic          granted = 1'b0;
    logic [AW-1:0] addr;
    logic [DW-1:0] payload;
    logic          vld, busy, full, err_len, err_ovf;

    portin_q #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DP)) dut (
        .clock  (clock),
        .reset  (reset),
        .frame_n(frame_n),
        .valid_n(valid_n),
        .di     (di),
        .granted(granted),
        .addr   (addr),
        .payload(payload),
        .vld    (vld),
        .busy   (busy),
        .full   (full),
        .err_len(err_len),
        .err_ovf(err_ovf)
    );

    always #5 clock = ~clock;

    logic [AW+DW-1:0] mq[$];
    int vecs = 0;
    int errs = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle of input; checks queue head before the edge and error pulses after.
    task automatic step(input logic fn, input logic vn, input logic d, input logic g,
                        input bit exp_len, input bit good_end, input logic [AW+DW-1:0] pkt);
        bit pop;
        bit ovf;
        logic [AW+DW-1:0] dropped;
        frame_n = fn;
        valid_n = vn;
        di      = d;
        granted = g;
        chk("vld", vld, mq.size() > 0);
        chk("full", full, mq.size() == DP);
        if (mq.size() > 0) chk("head", {addr, payload}, mq[0]);
        pop = g && (mq.size() > 0);
        ovf = good_end && (mq.size() == DP) && !pop;
        @(posedge clock);
        if (pop) dropped = mq.pop_front();
        if (good_end && !ovf) mq.push_back(pkt);
        #1;
        chk("err_len", err_len, exp_len);
        chk("err_ovf", err_ovf, ovf);
    endtask

    function automatic logic pick_g(input int gmode, input bit last);
        case (gmode)
            1:       return 1'b1;
            2:       return logic'($urandom_range(0, 1));
            3:       return last;
            default: return 1'b0;
        endcase
    endfunction

    // gmode: 0 never grant, 1 always, 2 random, 3 only on the last-bit cycle.
    task automatic send_frame(input logic [AW-1:0] a, input logic [DW-1:0] p,
                              input int na, input int np, input int gmode);
        bit bad_addr;
        bit good;
        bit last;
        logic d;
        bad_addr = (na < AW);
        good     = !bad_addr && (np == DW);
        for (int i = 0; i < na; i++) begin
            d = (i < AW) ? a[i] : logic'($urandom_range(0, 1));
            step(1'b0, 1'b1, d, pick_g(gmode, 1'b0), 1'b0, 1'b0, '0);
        end
        for (int j = 0; j < np; j++) begin
            last = (j == np - 1);
            d = (j < DW) ? p[j] : logic'($urandom_range(0, 1));
            step(last, 1'b0, d, pick_g(gmode, last),
                 (bad_addr && j == 0) || (!bad_addr && last && np != DW),
                 last && good, {a, p});
        end
        step(1'b1, 1'b1, 1'b0, pick_g(gmode == 3 ? 0 : gmode, 1'b0), 1'b0, 1'b0, '0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        logic [AW+DW-1:0] pk [5];
        int na, np, r;

        // Reset state
        #12;
        chk("rst_vld", vld, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_err_len", err_len, 1'b0);
        chk("rst_err_ovf", err_ovf, 1'b0);
        chk("rst_addr", addr, '0);
        chk("rst_payload", payload, '0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single frame, not granted: visible the cycle after the last bit
        send_frame(4'h5, 32'hDEAD_BEEF, AW, DW, 0);
        chk("single_vld", vld, 1'b1);
        chk("single_addr", addr, 4'h5);
        chk("single_payload", payload, 32'hDEAD_BEEF);
        chk("single_busy", busy, 1'b0);
        drain(3);

        // Five frames without grant: four queued, fifth overflows; drain in order
        for (int k = 0; k < 5; k++) pk[k] = {4'(k + 1), $urandom()};
        for (int k = 0; k < 5; k++) send_frame(pk[k][AW+DW-1:DW], pk[k][DW-1:0], AW, DW, 0);
        chk("ovf_full", full, 1'b1);
        chk("ovf_head", {addr, payload}, pk[0]);
        drain(6);

        // Full queue, fifth frame ends on a granted cycle: push and pop together
        for (int k = 0; k < 5; k++) pk[k] = {4'(k + 9), $urandom()};
        for (int k = 0; k < 4; k++) send_frame(pk[k][AW+DW-1:DW], pk[k][DW-1:0], AW, DW, 0);
        send_frame(pk[4][AW+DW-1:DW], pk[4][DW-1:0], AW, DW, 3);
        chk("pp_full", full, 1'b1);
        chk("pp_head", {addr, payload}, pk[1]);
        drain(6);

        // Length errors with a packet already queued, then a good frame
        send_frame(4'h3, 32'h1234_5678, AW, DW, 0);
        send_frame(4'h7, 32'hAAAA_5555, AW, DW - 1, 0);
        send_frame(4'h8, 32'h5555_AAAA, AW, DW + 1, 0);
        chk("len_vld", vld, 1'b1);
        send_frame(4'hC, 32'h0F0F_F0F0, AW, DW, 0);
        drain(4);

        // Short address: dropped until frame end
        send_frame(4'h6, 32'hCAFE_F00D, AW - 1, DW, 0);
        chk("short_vld", vld, 1'b0);
        chk("short_busy", busy, 1'b0);

        // Reset mid-payload with two packets queued
        send_frame(4'h1, 32'h1111_1111, AW, DW, 0);
        send_frame(4'h2, 32'h2222_2222, AW, DW, 0);
        for (int i = 0; i < AW; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        chk("mid_busy_pre", busy, 1'b1);
        reset = 1'b1;
        #2;
        mq.delete();
        chk("mid_vld", vld, 1'b0);
        chk("mid_busy", busy, 1'b0);
        chk("mid_full", full, 1'b0);
        frame_n = 1'b1;
        valid_n = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        send_frame(4'hA, 32'h0BAD_CAFE, AW, DW, 0);
        chk("post_rst_addr", addr, 4'hA);
        chk("post_rst_payload", payload, 32'h0BAD_CAFE);
        drain(3);

        // Randomized frames with random grant
        for (int k = 0; k < 60; k++) begin
            r  = $urandom_range(0, 9);
            na = (r == 0) ? AW - 1 : (r == 1) ? AW + 2 : AW;
            r  = $urandom_range(0, 9);
            np = (r == 0) ? DW - 1 : (r == 1) ? DW + 1 : DW;
            send_frame(4'($urandom_range(0, 15)), $urandom(), na, np, 2);
        end
        drain(6);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
